// File: rtl/shift_rows_stream.sv
// shift_rows_stream: byte-serial forward AES ShiftRows engine.
// A 16-byte state arrives one byte per beat (byte k = row k%4, col k/4).
// Each block fills one of two ping-pong banks. The permuted state then
// drains from that bank while the other bank fills, which sustains one
// byte per cycle.
// Optional feature macro: SHIFT_ROWS_INV_EN adds an inv input. It selects
// the inverse ShiftRows map for each block.
module shift_rows_stream (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
`ifdef SHIFT_ROWS_INV_EN
  input  logic       inv,
`endif
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       err
);

  // Output position -> input byte index for forward ShiftRows (row r rotates left by r).
  function automatic logic [3:0] fwd_idx(input logic [3:0] i);
    logic [3:0] v;
    case (i)
      4'd0:    v = 4'd0;
      4'd1:    v = 4'd5;
      4'd2:    v = 4'd10;
      4'd3:    v = 4'd15;
      4'd4:    v = 4'd4;
      4'd5:    v = 4'd9;
      4'd6:    v = 4'd14;
      4'd7:    v = 4'd3;
      4'd8:    v = 4'd8;
      4'd9:    v = 4'd13;
      4'd10:   v = 4'd2;
      4'd11:   v = 4'd7;
      4'd12:   v = 4'd12;
      4'd13:   v = 4'd1;
      4'd14:   v = 4'd6;
      4'd15:   v = 4'd11;
      default: v = 4'd0;
    endcase
    return v;
  endfunction

`ifdef SHIFT_ROWS_INV_EN
  // Output position -> input byte index for inverse ShiftRows (row r rotates right by r).
  function automatic logic [3:0] inv_idx(input logic [3:0] i);
    logic [3:0] v;
    case (i)
      4'd0:    v = 4'd0;
      4'd1:    v = 4'd13;
      4'd2:    v = 4'd10;
      4'd3:    v = 4'd7;
      4'd4:    v = 4'd4;
      4'd5:    v = 4'd1;
      4'd6:    v = 4'd14;
      4'd7:    v = 4'd11;
      4'd8:    v = 4'd8;
      4'd9:    v = 4'd5;
      4'd10:   v = 4'd2;
      4'd11:   v = 4'd15;
      4'd12:   v = 4'd12;
      4'd13:   v = 4'd9;
      4'd14:   v = 4'd6;
      4'd15:   v = 4'd3;
      default: v = 4'd0;
    endcase
    return v;
  endfunction
`endif

  logic [7:0] r_bank [0:1][0:15];
  logic [1:0] r_full;
  logic       r_wr_bank;
  logic [3:0] r_wr_cnt;
  logic       r_rd_bank;
  logic [3:0] r_rd_cnt;
  logic       r_err;
`ifdef SHIFT_ROWS_INV_EN
  logic [1:0] r_inv;
`endif

  logic       w_wr_en;
  logic       w_wr_done;
  logic       w_rd_en;
  logic       w_rd_done;
  logic       w_inv_sel;
  logic [3:0] w_src_idx;
  logic [1:0] w_full_nxt;
  logic       w_frame_bad;

  assign w_wr_en     = s_valid && s_ready;
  assign w_wr_done   = w_wr_en && (r_wr_cnt == 4'd15);
  assign w_rd_en     = m_valid && m_ready;
  assign w_rd_done   = w_rd_en && (r_rd_cnt == 4'd15);
  assign w_frame_bad = s_last != (r_wr_cnt == 4'd15);

`ifdef SHIFT_ROWS_INV_EN
  assign w_inv_sel = r_inv[r_rd_bank];
`else
  assign w_inv_sel = 1'b0;
`endif

  // Full flags: write completion and read completion always target different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end else begin
      w_full_nxt = w_full_nxt;
    end
    if (w_rd_done) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end else begin
      w_full_nxt = w_full_nxt;
    end
  end

  // Pick the source byte for the current output position from the drain bank.
  always_comb begin
`ifdef SHIFT_ROWS_INV_EN
    if (w_inv_sel) begin
      w_src_idx = inv_idx(r_rd_cnt);
    end else begin
      w_src_idx = fwd_idx(r_rd_cnt);
    end
`else
    if (w_inv_sel) begin
      w_src_idx = fwd_idx(r_rd_cnt);
    end else begin
      w_src_idx = fwd_idx(r_rd_cnt);
    end
`endif
  end

  assign s_ready = !r_full[r_wr_bank];
  assign m_valid = r_full[r_rd_bank];
  assign m_data  = r_bank[r_rd_bank][w_src_idx];
  assign m_last  = m_valid && (r_rd_cnt == 4'd15);
  assign err     = r_err;

  // Byte storage: capture accepted input bytes in arrival order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 16; i++) begin
          r_bank[b][i] <= 8'h00;
        end
      end
    end else if (w_wr_en) begin
      r_bank[r_wr_bank][r_wr_cnt] <= s_data;
    end
  end

  // Control: write/read pointers, full flags and the framing error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= 4'd0;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_err  <= w_wr_en && w_frame_bad;
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
      end
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + 4'd1;
      end
      if (w_rd_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

`ifdef SHIFT_ROWS_INV_EN
  // Map select: latch inv with byte 0 so the whole block drains with one map.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inv <= 2'b00;
    end else if (w_wr_en && (r_wr_cnt == 4'd0)) begin
      r_inv[r_wr_bank] <= inv;
    end
  end
`endif

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream. A behavioural model builds
// each expected block from row/column arithmetic and keeps a queue of
// expected output bytes.
module tb_shift_rows_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       err;
`ifdef SHIFT_ROWS_INV_EN
  logic       inv = 1'b0;
`endif

  shift_rows_stream dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
`ifdef SHIFT_ROWS_INV_EN
    .inv(inv),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  logic [7:0] cur_blk[$];
  logic [7:0] exp_q[$];
  bit         cur_inv;
  bit         err_pend;

  // observed / expected for the current cycle
  logic       obs_s_ready, obs_m_valid, obs_m_last, obs_err;
  logic [7:0] obs_m_data;
  logic       exp_s_ready, exp_m_valid, exp_m_last, exp_err;
  logic [7:0] exp_data;
  bit         fired, accepted;

  // State byte index (row + 4*col) that lands at output position out_idx.
  function automatic int src_of(input int out_idx, input bit inv_map);
    int r, c, col;
    r = out_idx % 4;
    c = out_idx / 4;
    col = inv_map ? ((c - r + 4) % 4) : ((c + r) % 4);
    return r + 4 * col;
  endfunction

  function automatic logic [7:0] rnd8();
    logic [31:0] v;
    v = $urandom;
    return v[7:0];
  endfunction

  task automatic model_clear();
    cur_blk.delete();
    exp_q.delete();
    err_pend = 1'b0;
    cur_inv = 1'b0;
  endtask

  // One clock: sample outputs at negedge, derive expectations, drive inputs, advance model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit mr, input bit iv);
    @(negedge clk);
    obs_s_ready = s_ready; obs_m_valid = m_valid; obs_m_data = m_data;
    obs_m_last = m_last; obs_err = err;
    exp_s_ready = (exp_q.size() <= 16);
    exp_m_valid = (exp_q.size() > 0);
    exp_m_last  = ((exp_q.size() % 16) == 1);
    exp_err     = err_pend;
    exp_data    = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    s_valid = v; s_data = d; s_last = l; m_ready = mr;
`ifdef SHIFT_ROWS_INV_EN
    inv = iv;
`endif
    accepted = v && obs_s_ready;
    fired    = obs_m_valid && mr;
    if (fired && exp_q.size() > 0) void'(exp_q.pop_front());
    err_pend = accepted && (l != (cur_blk.size() == 15));
    if (accepted) begin
      if (cur_blk.size() == 0) cur_inv = iv;
      cur_blk.push_back(d);
      if (cur_blk.size() == 16) begin
        for (int i = 0; i < 16; i++) exp_q.push_back(cur_blk[src_of(i, cur_inv)]);
        cur_blk.delete();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else passes++;
    checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %h want 00", m_data); else passes++;
    checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %b want 0", m_last); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single_block();
    logic [7:0] golden [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
    int outn = 0;
    int errs = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 16) cycle(1'b1, 8'(c), c == 15, 1'b1, 1'b0);
      else        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (obs_err === 1'b1) errs++;
      if (fired && outn < 16) begin
        checks++; if (obs_m_data !== golden[outn]) $display("FAIL single_data[%0d]: got %h want %h", outn, obs_m_data, golden[outn]); else passes++;
        checks++; if (obs_m_last !== (outn == 15)) $display("FAIL single_last[%0d]: got %b want %b", outn, obs_m_last, outn == 15); else passes++;
        outn++;
      end
    end
    checks++; if (outn != 16) $display("FAIL single_count: got %0d want 16", outn); else passes++;
    checks++; if (errs != 0) $display("FAIL single_err: got %0d pulses want 0", errs); else passes++;
  endtask

  task automatic test_back_to_back();
    int first = -1, lastv = -1, nvalid = 0, drops = 0;
    for (int c = 0; c < 70; c++) begin
      if (c < 48) cycle(1'b1, rnd8(), (c % 16) == 15, 1'b1, 1'b0);
      else        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (c < 48 && obs_s_ready !== 1'b1) drops++;
      if (obs_m_valid === 1'b1) begin
        if (first < 0) first = c;
        lastv = c;
        nvalid++;
        checks++; if (obs_m_data !== exp_data) $display("FAIL b2b_data@%0d: got %h want %h", c, obs_m_data, exp_data); else passes++;
      end
    end
    checks++; if (drops != 0) $display("FAIL b2b_s_ready: dropped %0d cycles want 0", drops); else passes++;
    checks++; if (first != 16) $display("FAIL b2b_first_valid: got cycle %0d want 16", first); else passes++;
    checks++; if (nvalid != 48) $display("FAIL b2b_valid_count: got %0d want 48", nvalid); else passes++;
    checks++; if (lastv != 63) $display("FAIL b2b_last_valid: got cycle %0d want 63", lastv); else passes++;
  endtask

  task automatic test_backpressure();
    int acc = 0, nfire = 0, bank0_done = -1, ready_back = -1, c = 0;
    for (int k = 0; k < 36; k++) begin
      cycle(1'b1, rnd8(), (acc % 16) == 15, 1'b0, 1'b0);
      if (accepted) acc++;
    end
    checks++; if (acc != 32) $display("FAIL bp_accepted: got %0d want 32", acc); else passes++;
    checks++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready_low: got %b want 0", s_ready); else passes++;
    checks++; if (m_valid !== 1'b1) $display("FAIL bp_m_valid: got %b want 1", m_valid); else passes++;
    while ((exp_q.size() > 0 || acc < 48) && c < 200) begin
      cycle(acc < 48, rnd8(), (acc % 16) == 15, 1'b1, 1'b0);
      if (accepted) acc++;
      if (ready_back < 0 && obs_s_ready === 1'b1) ready_back = c;
      checks++; if (obs_s_ready !== exp_s_ready) $display("FAIL bp_s_ready@%0d: got %b want %b", c, obs_s_ready, exp_s_ready); else passes++;
      if (fired) begin
        checks++; if (obs_m_data !== exp_data) $display("FAIL bp_data@%0d: got %h want %h", c, obs_m_data, exp_data); else passes++;
        nfire++;
        if (nfire == 16) bank0_done = c;
      end
      c++;
    end
    checks++; if (ready_back != bank0_done + 1) $display("FAIL bp_ready_return: got cycle %0d want %0d", ready_back, bank0_done + 1); else passes++;
    checks++; if (nfire != 48) $display("FAIL bp_no_loss: got %0d outputs want 48", nfire); else passes++;
  endtask

  task automatic test_framing();
    int pulses = 0, first_pulse = -1;
    for (int c = 0; c < 56; c++) begin
      if (c < 16)      cycle(1'b1, rnd8(), (c == 7) || (c == 15), 1'b1, 1'b0);
      else if (c < 32) cycle(1'b1, rnd8(), 1'b0, 1'b1, 1'b0);
      else             cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checks++; if (obs_err !== exp_err) $display("FAIL frame_err@%0d: got %b want %b", c, obs_err, exp_err); else passes++;
      if (obs_err === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c;
      end
      if (fired) begin
        checks++; if (obs_m_data !== exp_data) $display("FAIL frame_data@%0d: got %h want %h", c, obs_m_data, exp_data); else passes++;
      end
    end
    checks++; if (pulses != 2) $display("FAIL frame_pulses: got %0d want 2", pulses); else passes++;
    checks++; if (first_pulse != 8) $display("FAIL frame_first_pulse: got cycle %0d want 8", first_pulse); else passes++;
    checks++; if (exp_q.size() != 0) $display("FAIL frame_drain: %0d bytes left want 0", exp_q.size()); else passes++;
  endtask

  task automatic test_midblock_reset();
    logic [7:0] head [4] = '{8'h10, 8'h15, 8'h1A, 8'h1F};
    int outn = 0;
    for (int k = 0; k < 9; k++) cycle(1'b1, rnd8(), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) $display("FAIL mid_reset_s_ready: got %b want 1", s_ready); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL mid_reset_m_valid: got %b want 0", m_valid); else passes++;
    checks++; if (m_data !== 8'h00) $display("FAIL mid_reset_m_data: got %h want 00", m_data); else passes++;
    checks++; if (m_last !== 1'b0) $display("FAIL mid_reset_m_last: got %b want 0", m_last); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL mid_reset_err: got %b want 0", err); else passes++;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 40; c++) begin
      if (c < 16) cycle(1'b1, 8'(8'h10 + c), c == 15, 1'b1, 1'b0);
      else        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (fired) begin
        checks++; if (obs_m_data !== exp_data) $display("FAIL mid_data[%0d]: got %h want %h", outn, obs_m_data, exp_data); else passes++;
        if (outn < 4) begin
          checks++; if (obs_m_data !== head[outn]) $display("FAIL mid_head[%0d]: got %h want %h", outn, obs_m_data, head[outn]); else passes++;
        end
        outn++;
      end
    end
    checks++; if (outn != 16) $display("FAIL mid_count: got %0d want 16", outn); else passes++;
  endtask

  task automatic test_random();
    int acc = 0, c = 0;
    bit v, mr, lst, iv;
    iv = 1'b0;
    while (c < 400 && (c < 300 || exp_q.size() > 0 || (acc % 16) != 0)) begin
      v   = (c < 300) ? ($urandom_range(3, 0) != 0) : ((acc % 16) != 0);
      mr  = (c < 300) ? ($urandom_range(2, 0) != 0) : 1'b1;
      lst = ((acc % 16) == 15);
      if ($urandom_range(7, 0) == 0) lst = !lst;
`ifdef SHIFT_ROWS_INV_EN
      if ((acc % 16) == 0) iv = $urandom_range(1, 0) != 0;
`endif
      cycle(v, rnd8(), lst, mr, iv);
      if (accepted) acc++;
      checks++; if (obs_s_ready !== exp_s_ready) $display("FAIL rand_s_ready@%0d: got %b want %b", c, obs_s_ready, exp_s_ready); else passes++;
      checks++; if (obs_m_valid !== exp_m_valid) $display("FAIL rand_m_valid@%0d: got %b want %b", c, obs_m_valid, exp_m_valid); else passes++;
      checks++; if (obs_err !== exp_err) $display("FAIL rand_err@%0d: got %b want %b", c, obs_err, exp_err); else passes++;
      if (exp_m_valid) begin
        checks++; if (obs_m_data !== exp_data) $display("FAIL rand_data@%0d: got %h want %h", c, obs_m_data, exp_data); else passes++;
        checks++; if (obs_m_last !== exp_m_last) $display("FAIL rand_last@%0d: got %b want %b", c, obs_m_last, exp_m_last); else passes++;
      end
      c++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL rand_drain: %0d bytes left want 0", exp_q.size()); else passes++;
  endtask

`ifdef SHIFT_ROWS_INV_EN
  task automatic test_inv();
    logic [7:0] golden [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    int outn = 0;
    for (int c = 0; c < 90; c++) begin
      if (c < 64) cycle(1'b1, (c < 16) ? 8'(c) : rnd8(), (c % 16) == 15, 1'b1, ((c / 16) % 2) == 0);
      else        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (fired) begin
        checks++; if (obs_m_data !== exp_data) $display("FAIL inv_data[%0d]: got %h want %h", outn, obs_m_data, exp_data); else passes++;
        if (outn < 16) begin
          checks++; if (obs_m_data !== golden[outn]) $display("FAIL inv_golden[%0d]: got %h want %h", outn, obs_m_data, golden[outn]); else passes++;
        end
        outn++;
      end
    end
    checks++; if (outn != 64) $display("FAIL inv_count: got %0d want 64", outn); else passes++;
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_midblock_reset();
    test_random();
`ifdef SHIFT_ROWS_INV_EN
    test_inv();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
